// File: rtl/button_pkg.sv
// Shared types and defaults for the pushbutton conditioning path.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEFAULT_NUM_BUTTONS = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus: raw board inputs in, clean event pulses and debounced levels out.
interface button_conditioner_if
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS = DEFAULT_NUM_BUTTONS
);
  logic [NUM_BUTTONS-1:0] raw_buttons;
  logic [NUM_BUTTONS-1:0] pushbuttons;
  logic [NUM_BUTTONS-1:0] buttons_held;
  logic                   event_pending;

  modport slave (
    input  raw_buttons,
    output pushbuttons,
    output buttons_held,
    output event_pending
  );

  modport master (
    output raw_buttons,
    input  pushbuttons,
    input  buttons_held,
    input  event_pending
  );
endinterface

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM, accept strobe.
// Optional auto-repeat while held: define BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic held_o,
  output logic accept_o
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic           POL      = (ACTIVE_LOW != 0);

  logic             pressed;
  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  btn_state_t       state_q;
  logic             press_done;
  logic             rpt_fire;

  assign pressed = raw_i ^ POL;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // The strobe is decoded from registered state so the pending buffer can
  // capture it on the very edge the FSM enters HELD.
  assign press_done = (state_q == PRESS_WAIT) && sync2_q && (cnt_q >= CNT_LAST);
  assign accept_o   = press_done | rpt_fire;
  assign held_o     = (state_q == HELD) || (state_q == RELEASE_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      sync1_q <= pressed;
      sync2_q <= sync1_q;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        HELD: begin
          if (!sync2_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam int               RPT_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD =
    (REPEAT_PERIOD >= REPEAT_DELAY) ? '0 : RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rcnt_q;

  assign rpt_fire = (state_q == HELD) && sync2_q && (rcnt_q >= RPT_LAST);

  // Reloading to DELAY-PERIOD makes later repeats land every PERIOD cycles;
  // RELEASE_WAIT holds the count so a release bounce resumes where it left off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q <= '0;
    end else if (state_q == HELD && sync2_q) begin
      rcnt_q <= rpt_fire ? RPT_RELOAD : rcnt_q + RPT_W'(1);
    end else if (state_q == IDLE || state_q == PRESS_WAIT) begin
      rcnt_q <= '0;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BUTTONS raw pushbuttons and issues one-hot, one-cycle events,
// lowest index first. Auto-repeat: define BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  button_conditioner_if.slave bus
);

  logic [NUM_BUTTONS-1:0] held;
  logic [NUM_BUTTONS-1:0] accept;
  logic [NUM_BUTTONS-1:0] pending_q;
  logic [NUM_BUTTONS-1:0] pending_d;
  logic [NUM_BUTTONS-1:0] issue;
  logic [NUM_BUTTONS-1:0] push_q;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (bus.raw_buttons[g]),
      .held_o  (held[g]),
      .accept_o(accept[g])
    );
  end

  // Isolate the lowest set pending bit; a fresh accept on the same bit wins
  // over its clear, so a press landing on its own issue cycle is not lost.
  assign issue     = pending_q & (-pending_q);
  assign pending_d = (pending_q & ~issue) | accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      push_q    <= '0;
    end else begin
      pending_q <= pending_d;
      push_q    <= issue;
    end
  end

  assign bus.pushbuttons   = push_q;
  assign bus.buttons_held  = held;
  assign bus.event_pending = |pending_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with 4-cycle debounce, active-high inputs.
module tb_button_conditioner;
  import button_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  button_conditioner_if #(.NUM_BUTTONS(3)) bi ();

  button_conditioner #(
    .NUM_BUTTONS    (3),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (0),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bi)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    logic [2:0]  seen;
    logic [2:0]  hseen;
    int          nev;
    int          pos[3];

    reset = 1'b1;
    bi.raw_buttons = 3'b000;
    step(2);
    chk("rst_push", bi.pushbuttons, 3'b000);
    chk("rst_held", bi.buttons_held, 3'b000);
    chk("rst_pend", {2'b00, bi.event_pending}, 3'b000);
    reset = 1'b0;
    step(2);

    // Clean press of button 0: event after the 7th edge from the change
    bi.raw_buttons = 3'b001;
    step(6);
    chk("t1_push_early", bi.pushbuttons, 3'b000);
    chk("t1_pend", {2'b00, bi.event_pending}, 3'b001);
    chk("t1_held", bi.buttons_held, 3'b001);
    step(1);
    chk("t1_push", bi.pushbuttons, 3'b001);
    chk("t1_pend_clr", {2'b00, bi.event_pending}, 3'b000);
    step(1);
    chk("t1_push_once", bi.pushbuttons, 3'b000);
    step(12);
    chk("t1_hold_push", bi.pushbuttons, 3'b000);
    chk("t1_hold_held", bi.buttons_held, 3'b001);
    bi.raw_buttons = 3'b000;
    step(5);
    chk("t1_rel_held", bi.buttons_held, 3'b001);
    step(1);
    chk("t1_rel_idle", bi.buttons_held, 3'b000);

    // Bounce on button 1 never reaches the debounce count
    pat   = 16'b0000_0000_0000_1011;
    seen  = '0;
    hseen = '0;
    for (int i = 0; i < 16; i++) begin
      bi.raw_buttons = pat[i] ? 3'b010 : 3'b000;
      step(1);
      seen  |= bi.pushbuttons;
      hseen |= bi.buttons_held;
    end
    chk("t2_push", seen, 3'b000);
    chk("t2_held", hseen, 3'b000);

    // Buttons 0 and 2 together: issued lowest first on consecutive cycles
    bi.raw_buttons = 3'b101;
    step(6);
    chk("t3_push_early", bi.pushbuttons, 3'b000);
    chk("t3_pend", {2'b00, bi.event_pending}, 3'b001);
    step(1);
    chk("t3_push0", bi.pushbuttons, 3'b001);
    chk("t3_pend_mid", {2'b00, bi.event_pending}, 3'b001);
    step(1);
    chk("t3_push2", bi.pushbuttons, 3'b100);
    chk("t3_pend_end", {2'b00, bi.event_pending}, 3'b000);
    chk("t3_held", bi.buttons_held, 3'b101);
    bi.raw_buttons = 3'b000;
    step(8);
    chk("t3_rel", bi.buttons_held, 3'b000);

    // Release bounce on button 2 produces no second event
    nev = 0;
    bi.raw_buttons = 3'b100;
    repeat (10) begin step(1); if (bi.pushbuttons[2]) nev++; end
    bi.raw_buttons = 3'b000;
    step(1);
    if (bi.pushbuttons[2]) nev++;
    bi.raw_buttons = 3'b100;
    repeat (10) begin step(1); if (bi.pushbuttons[2]) nev++; end
    bi.raw_buttons = 3'b000;
    repeat (8) begin step(1); if (bi.pushbuttons[2]) nev++; end
    chk_int("t4_events", nev, 1);
    chk("t4_held", bi.buttons_held, 3'b000);

    // Reset with button 0 pending and button 1 in PRESS_WAIT
    bi.raw_buttons = 3'b001;
    step(2);
    bi.raw_buttons = 3'b011;
    step(4);
    chk("t5_pre_pend", {2'b00, bi.event_pending}, 3'b001);
    chk("t5_pre_held", bi.buttons_held, 3'b001);
    reset = 1'b1;
    #1;
    chk("t5_rst_push", bi.pushbuttons, 3'b000);
    chk("t5_rst_held", bi.buttons_held, 3'b000);
    chk("t5_rst_pend", {2'b00, bi.event_pending}, 3'b000);
    step(2);
    reset = 1'b0;
    step(6);
    chk("t5_push_early", bi.pushbuttons, 3'b000);
    step(1);
    chk("t5_push0", bi.pushbuttons, 3'b001);
    step(1);
    chk("t5_push1", bi.pushbuttons, 3'b010);
    step(1);
    chk("t5_push_done", bi.pushbuttons, 3'b000);
    bi.raw_buttons = 3'b000;
    step(8);

    // Long hold of button 1
    nev  = 0;
    pos  = '{-1, -1, -1};
    seen = '0;
    bi.raw_buttons = 3'b010;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (bi.pushbuttons != 3'b000) begin
        if (nev < 3) pos[nev] = i;
        nev++;
        seen |= bi.pushbuttons;
      end
    end
    chk("t6_bits", seen, 3'b010);
    chk_int("t6_first", pos[0], 7);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    chk_int("t6_count", nev, 3);
    chk_int("t6_rep1", pos[1], 27);
    chk_int("t6_rep2", pos[2], 35);
`else
    chk_int("t6_count", nev, 1);
`endif
    bi.raw_buttons = 3'b000;
    step(8);
    chk("t6_rel", bi.buttons_held, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front end of the pushbutton path for the number-guessing game.
- Takes raw, bouncing, asynchronous board pushbuttons and produces the clean one-cycle, one-hot `pushbuttons` event vector that the digit input controller consumes.
- Each press yields exactly one event; simultaneous presses are buffered and issued on consecutive cycles.

Parameters:
- NUM_BUTTONS, 3, number of button channels (matches controller `pushbuttons` width).
- DEBOUNCE_CYCLES, 500000, consecutive stable synced cycles required to accept a press or release (benches override to 4).
- ACTIVE_LOW, 1, 1 = raw inputs read 0 when pressed (board default); 0 = active-high.
- REPEAT_DELAY, 25000000, cycles of continuous hold before the first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeats (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- raw_buttons  in  NUM_BUTTONS  unsynchronised board pushbuttons.
- pushbuttons  out  NUM_BUTTONS  registered event pulses; at most one bit high per cycle.
- buttons_held  out  NUM_BUTTONS  debounced level per button (1 while in HELD).
- event_pending  out  1  one or more accepted presses are not yet issued.

Behaviour:
- Reset: all sync flops, counters, pending bits and outputs go to 0; all channel FSMs go to IDLE. Reset is asynchronous and overrides everything.
- Normalisation: pressed = raw_buttons ^ {NUM_BUTTONS{ACTIVE_LOW}}.
- Synchroniser: two flops per bit. Only the second-stage value (sync) is used downstream.
- Channel FSM, one per button:
  - IDLE: sync=1 -> PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - sync=0 -> IDLE, cnt=0 (bounce rejected).
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD and raise an accept strobe for one cycle.
    - otherwise cnt++.
  - HELD:
    - sync=0 -> RELEASE_WAIT with cnt=1.
    - sync=1 -> remain in HELD.
  - RELEASE_WAIT:
    - sync=1 -> HELD, cnt=0 (release bounce ignored; no new event).
    - sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - otherwise cnt++.
- Counter: width $clog2(DEBOUNCE_CYCLES+1); it saturates and never wraps.
- buttons_held[i] = 1 in HELD and RELEASE_WAIT.
- Pending buffer:
  - An accept strobe sets pending[i].
  - Each cycle, the lowest-index set pending bit is registered onto pushbuttons and cleared.
  - When no bit is pending, pushbuttons=0.
  - event_pending = |pending.
- Simultaneous events:
  - Accept and issue of the same bit in one cycle: the bit stays set (set wins).
  - Two accepts in the same cycle are issued lowest index first, one cycle apart.
- Latency: for a clean press with raw stable before posedge k, pushbuttons[i] is high for exactly the one cycle following posedge k+DEBOUNCE_CYCLES+2, provided no lower pending bit is queued.
- Reset mid-operation:
  - Pending events are discarded.
  - A button still held when reset deasserts is treated as a fresh press and generates one event after the full latency.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs.
  - At REPEAT_DELAY cycles of continuous HELD, an accept strobe fires, then again every REPEAT_PERIOD cycles.
  - Leaving HELD clears the repeat counter.
  - RELEASE_WAIT pauses the counter and a bounce back to HELD resumes it.
- Undefined: no repeat logic is present; a hold of any length gives exactly one event.

Decomposition:
- Package `button_pkg`:
  - typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t.
  - localparam DEFAULT_NUM_BUTTONS=3.
- Sub-module `button_debounce`:
  - One channel: synchroniser, FSM, counter, optional repeat.
  - Outputs held and accept.
  - button_conditioner instantiates NUM_BUTTONS copies via generate and owns the pending buffer and priority issue.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press of button 0 held 20 cycles -> pushbuttons=3'b001 for exactly 1 cycle, 6 edges after input change; buttons_held[0]=1 until 6 cycles after release.
- Bounce on button 1: high 2 cycles, low, high 1 cycle, low -> pushbuttons stays 3'b000; buttons_held stays 0.
- Buttons 0 and 2 pressed on the same edge -> 3'b001 then 3'b100 on the next cycle; event_pending=1 for one cycle between them.
- Release bounce: button 2 held, 1-cycle drop, held again -> only one 3'b100 event in total.
- Reset asserted mid PRESS_WAIT and with one pending bit, button still held -> all outputs 0 immediately; one event 6 edges after reset deasserts.
- AUTO_REPEAT_EN defined, button 1 held 40 cycles -> initial 3'b010 event, then repeat events 20 and 28 cycles after accept.
